// File: rtl/ac_pkg.sv
// Shared types and constants for the lane merger and its round-robin selector.
package ac_pkg;

  localparam int DEF_NUM_LANES   = 9;
  localparam int DEF_COUNT_BYTES = 2;
  localparam int BYTE_W          = 8;
  localparam int LANE_CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_PREFETCH,
    ST_HEADER,
    ST_DATA,
    ST_DONE
  } state_t;

  // Width of a lane index; at least one bit so single-lane builds still elaborate.
  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ac_rr_select.sv
// Combinational round-robin picker: first set bit of i_mask at or after i_ptr,
// wrapping from the top lane back to lane 0.
module ac_rr_select #(
  parameter int NUM_LANES = ac_pkg::DEF_NUM_LANES,
  parameter int IDX_W     = ac_pkg::lane_idx_w(NUM_LANES)
) (
  input  logic [IDX_W-1:0]     i_ptr,
  input  logic [NUM_LANES-1:0] i_mask,
  output logic [IDX_W-1:0]     o_sel,
  output logic                 o_found
);

  // Scan offsets from farthest to nearest so the closest eligible lane wins.
  always_comb begin
    int idx;
    o_sel   = '0;
    o_found = 1'b0;
    idx     = 0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (i_mask[idx]) begin
        o_found = 1'b1;
        o_sel   = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/ac_lane_merger.sv
// Merges the byte streams of several coder lanes into one stream: a big-endian
// byte-count header followed by round-robin lane data, one buffered byte per lane.
module ac_lane_merger
  import ac_pkg::*;
#(
  parameter int NUM_LANES   = DEF_NUM_LANES,
  parameter int COUNT_BYTES = DEF_COUNT_BYTES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_in,
  input  logic [NUM_LANES*LANE_CNT_W-1:0] lane_count_in,
  output logic [NUM_LANES-1:0]           lane_rd_en_out,
  input  logic [NUM_LANES*BYTE_W-1:0]    lane_byte_in,
  input  logic [NUM_LANES-1:0]           lane_valid_in,
  output logic [BYTE_W-1:0]              data_out,
  output logic                           valid_out,
  input  logic                           ready_in,
  output logic                           last_out,
  output logic                           busy_out,
  output logic                           done_out,
  output logic                           overflow_out
);

  localparam int IDX_W  = lane_idx_w(NUM_LANES);
  localparam int TOT_W  = COUNT_BYTES * BYTE_W;
  localparam int LEFT_W = LANE_CNT_W + 4;  // exact byte total for up to 16 lanes
  localparam int HDR_W  = 2;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_lane;
  logic [TOT_W-1:0]      r_total;
  logic [LEFT_W-1:0]     r_left;
  logic [HDR_W-1:0]      r_hdr_idx;
  logic [BYTE_W-1:0]     r_buf [NUM_LANES];
  logic [LANE_CNT_W-1:0] r_rem [NUM_LANES];
  logic [NUM_LANES-1:0]  r_full;
  logic [NUM_LANES-1:0]  r_outst;
  logic [NUM_LANES-1:0]  r_issued;
  logic [NUM_LANES-1:0]  r_pf_rd;
  logic [BYTE_W-1:0]     r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;

  logic [LANE_CNT_W-1:0] w_cnt  [NUM_LANES];
  logic [BYTE_W-1:0]     w_byte [NUM_LANES];
  logic [NUM_LANES-1:0]  w_nz;
  logic [NUM_LANES-1:0]  w_refill;
  logic [NUM_LANES-1:0]  w_mask;
  logic [IDX_W-1:0]      w_ptr;
  logic [IDX_W-1:0]      w_sel;
  logic [IDX_W-1:0]      w_sel_next;
  logic                  w_found;
  logic [TOT_W:0]        w_sum;
  logic [HDR_W-1:0]      w_hdr_next;
  logic                  w_accept;
  logic                  w_slot_free;

  assign w_accept    = r_valid && ready_in;
  assign w_slot_free = !r_valid || ready_in;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    assign w_cnt[gi]  = lane_count_in[gi*LANE_CNT_W +: LANE_CNT_W];
    assign w_byte[gi] = lane_byte_in[gi*BYTE_W +: BYTE_W];
    assign w_nz[gi]   = |w_cnt[gi];
    // Refill a lane in the very cycle its presented byte is taken downstream.
    assign w_refill[gi] = (r_state == ST_DATA) && w_accept &&
                          (r_lane == IDX_W'(gi)) && (r_rem[gi] != '0);
  end

  // Prefetch scans lanes from 0 upward; data phase scans from the rr pointer.
  assign w_ptr  = (r_state == ST_PREFETCH) ? '0 : r_ptr;
  assign w_mask = (r_state == ST_PREFETCH) ? (w_nz & ~r_issued) : (r_full | r_outst);

  ac_rr_select #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .i_ptr   (w_ptr),
    .i_mask  (w_mask),
    .o_sel   (w_sel),
    .o_found (w_found)
  );

  assign w_sel_next = (w_sel == IDX_W'(NUM_LANES - 1)) ? '0 : w_sel + IDX_W'(1);
  assign w_sum      = {1'b0, r_total} + (TOT_W + 1)'(w_cnt[r_idx]);
  assign w_hdr_next = r_hdr_idx - HDR_W'(1);

  assign lane_rd_en_out = r_pf_rd | w_refill;
  assign data_out       = r_data;
  assign valid_out      = r_valid;
  assign last_out       = r_last;
  assign busy_out       = r_busy;
  assign done_out       = r_done;
  assign overflow_out   = r_overflow;

  // Merge sequencer: sum counts, prefetch one byte per lane, header, data, done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_ptr      <= '0;
      r_lane     <= '0;
      r_total    <= '0;
      r_left     <= '0;
      r_hdr_idx  <= '0;
      r_full     <= '0;
      r_outst    <= '0;
      r_issued   <= '0;
      r_pf_rd    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_buf[l] <= '0;
        r_rem[l] <= '0;
      end
    end else begin
      r_pf_rd <= '0;

      // Returned bytes only land in lanes that actually have a read in flight.
      for (int l = 0; l < NUM_LANES; l++) begin
        if (lane_valid_in[l] && r_outst[l]) begin
          r_buf[l]   <= w_byte[l];
          r_full[l]  <= 1'b1;
          r_outst[l] <= 1'b0;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_state    <= ST_SUM;
            r_idx      <= '0;
            r_total    <= '0;
            r_left     <= '0;
            r_overflow <= 1'b0;
            r_full     <= '0;
            r_outst    <= '0;
            r_issued   <= '0;
            r_busy     <= 1'b1;
          end
        end

        ST_SUM: begin
          r_total <= w_sum[TOT_W-1:0];
          if (w_sum[TOT_W]) r_overflow <= 1'b1;
          r_left <= r_left + LEFT_W'(w_cnt[r_idx]);
          if (r_idx == IDX_W'(NUM_LANES - 1)) begin
            r_state <= ST_PREFETCH;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        ST_PREFETCH: begin
          if (w_found) begin
            r_pf_rd[w_sel]  <= 1'b1;
            r_outst[w_sel]  <= 1'b1;
            r_issued[w_sel] <= 1'b1;
            r_rem[w_sel]    <= w_cnt[w_sel] - LANE_CNT_W'(1);
          end else begin
            r_state   <= ST_HEADER;
            r_hdr_idx <= HDR_W'(COUNT_BYTES - 1);
            r_data    <= r_total[TOT_W-1 -: BYTE_W];
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
          end
        end

        ST_HEADER: begin
          if (w_accept) begin
            if (r_hdr_idx != '0) begin
              r_hdr_idx <= w_hdr_next;
              r_data    <= r_total[int'(w_hdr_next)*BYTE_W +: BYTE_W];
              r_last    <= (w_hdr_next == '0) && (r_left == '0);
            end else if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_valid <= 1'b0;
              r_ptr   <= '0;
              r_state <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (w_accept && (r_rem[r_lane] != '0)) begin
            r_rem[r_lane]   <= r_rem[r_lane] - LANE_CNT_W'(1);
            r_outst[r_lane] <= 1'b1;
          end
          if (w_accept && r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_slot_free) begin
            if (w_found && r_full[w_sel]) begin
              r_data        <= r_buf[w_sel];
              r_lane        <= w_sel;
              r_valid       <= 1'b1;
              r_last        <= (r_left == LEFT_W'(1));
              r_left        <= r_left - LEFT_W'(1);
              r_full[w_sel] <= 1'b0;
              r_ptr         <= w_sel_next;
            end else begin
              // Selected lane still waiting on its read: bubble, keep the pointer.
              r_valid <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_lane_merger.sv
// Scoreboard bench for ac_lane_merger: stimulus pushes expected bytes, a monitor
// pops and compares on every accepted output byte.
`timescale 1ns/1ps
module tb_ac_lane_merger;
  import ac_pkg::*;

  localparam int N  = 9;
  localparam int CB = 2;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_in = 1'b0;
  logic            ready_in = 1'b1;
  logic [N*16-1:0] lane_count_in = '0;
  logic [N-1:0]    lane_rd_en_out;
  logic [N*8-1:0]  lane_byte_in = '0;
  logic [N-1:0]    lane_valid_in = '0;
  logic [7:0]      data_out;
  logic            valid_out, last_out, busy_out, done_out, overflow_out;

  int   n_vec = 0;
  int   n_miss = 0;
  exp_t q[$];
  bit   strict = 1'b1;
  bit   rnd_ready = 1'b0;
  int   rd_cnt[N];
  int   rd_idx[N];

  always #5 clk = ~clk;

  ac_lane_merger #(.NUM_LANES(N), .COUNT_BYTES(CB)) dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in),
    .lane_count_in(lane_count_in), .lane_rd_en_out(lane_rd_en_out),
    .lane_byte_in(lane_byte_in), .lane_valid_in(lane_valid_in),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .last_out(last_out), .busy_out(busy_out), .done_out(done_out),
    .overflow_out(overflow_out)
  );

  task automatic push(input logic [7:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, need %0h", name, act, req);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 0);
    chk({tag, "_valid_out"}, 32'(valid_out), 0);
    chk({tag, "_last_out"}, 32'(last_out), 0);
    chk({tag, "_busy_out"}, 32'(busy_out), 0);
    chk({tag, "_done_out"}, 32'(done_out), 0);
    chk({tag, "_overflow_out"}, 32'(overflow_out), 0);
    chk({tag, "_rd_en"}, 32'(lane_rd_en_out), 0);
  endtask

  task automatic clear_lane_stats();
    for (int l = 0; l < N; l++) begin
      rd_cnt[l] = 0;
      rd_idx[l] = 0;
    end
  endtask

  task automatic do_start();
    @(posedge clk); #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    chk("busy_after_start", 32'(busy_out), 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done_out === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_miss++;
      $display("FAIL wait_done: done_out not seen within %0d cycles, need a pulse", budget);
    end
    chk("queue_drained", 32'(q.size()), 0);
  endtask

  task automatic push_all_two();
    push(8'h00, 1'b0);
    push(8'h12, 1'b0);
    for (int r = 0; r < 2; r++)
      for (int l = 0; l < N; l++)
        push(8'(l * 16 + r), (r == 1) && (l == N - 1));
  endtask

  task automatic push_sparse();
    push(8'h00, 1'b0);
    push(8'h04, 1'b0);
    push(8'h00, 1'b0);
    push(8'h20, 1'b0);
    push(8'h01, 1'b0);
    push(8'h02, 1'b1);
  endtask

  task automatic set_sparse_counts();
    lane_count_in = '0;
    lane_count_in[15:0]  = 16'd3;
    lane_count_in[47:32] = 16'd1;
  endtask

  // Lane model: answer each read pulse one cycle later with byte {lane, index}.
  initial begin : responder
    logic [N-1:0] pend;
    forever begin
      @(negedge clk);
      pend = rst_n ? lane_rd_en_out : '0;
      @(posedge clk); #1;
      for (int l = 0; l < N; l++) begin
        lane_valid_in[l] = pend[l] && rst_n;
        if (pend[l] && rst_n) begin
          lane_byte_in[l*8 +: 8] = 8'(l * 16 + (rd_idx[l] % 16));
          rd_idx[l]++;
        end
      end
    end
  end

  // Downstream ready: always high, or random when back-pressure is exercised.
  initial begin : ready_drv
    forever begin
      @(posedge clk); #1;
      ready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, done pulse timing, read counts.
  initial begin : monitor
    exp_t       e;
    logic       prev_stall;
    logic [7:0] prev_d;
    logic       prev_l;
    bit         done_exp;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    done_exp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        done_exp = 1'b0;
      end else begin
        if (prev_stall) begin
          n_vec++;
          if (valid_out !== 1'b1 || data_out !== prev_d || last_out !== prev_l) begin
            n_miss++;
            $display("FAIL stall_hold: got v=%b d=%02h l=%b, need v=1 d=%02h l=%b",
                     valid_out, data_out, last_out, prev_d, prev_l);
          end
        end
        if (done_exp) begin
          n_vec++;
          if (done_out !== 1'b1) begin
            n_miss++;
            $display("FAIL done_pulse: got done_out=%b, need 1 one cycle after last", done_out);
          end
        end else if (done_out === 1'b1) begin
          n_vec++;
          n_miss++;
          $display("FAIL done_spurious: got done_out=1, need 0");
        end
        done_exp = 1'b0;
        for (int l = 0; l < N; l++)
          if (lane_rd_en_out[l] === 1'b1) rd_cnt[l]++;
        if (valid_out === 1'b1 && ready_in === 1'b1) begin
          if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (data_out !== e.d || last_out !== e.l) begin
              n_miss++;
              $display("FAIL out_byte: got d=%02h l=%b, need d=%02h l=%b",
                       data_out, last_out, e.d, e.l);
            end
          end else if (strict) begin
            n_vec++;
            n_miss++;
            $display("FAIL extra_byte: got d=%02h l=%b, need no output", data_out, last_out);
          end
          if (last_out === 1'b1) done_exp = 1'b1;
        end
        prev_stall = (valid_out === 1'b1) && (ready_in === 1'b0);
        prev_d = data_out;
        prev_l = last_out;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    clear_lane_stats();

    // Power-on reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("por");
    @(negedge clk) rst_n = 1'b1;

    // All lanes two bytes, ready always high
    lane_count_in = {N{16'd2}};
    clear_lane_stats();
    push_all_two();
    do_start();
    wait_done(400);
    for (int l = 0; l < N; l++) chk($sformatf("t1_rd_cnt_l%0d", l), 32'(rd_cnt[l]), 2);
    chk("t1_overflow", 32'(overflow_out), 0);
    @(negedge clk);
    chk("t1_busy_idle", 32'(busy_out), 0);

    // Sparse lanes {3,0,1,0...}
    set_sparse_counts();
    clear_lane_stats();
    push_sparse();
    do_start();
    wait_done(400);
    for (int l = 0; l < N; l++)
      chk($sformatf("t2_rd_cnt_l%0d", l), 32'(rd_cnt[l]), (l == 0) ? 3 : (l == 2) ? 1 : 0);

    // All lanes empty: header only, last on second byte
    lane_count_in = '0;
    clear_lane_stats();
    push(8'h00, 1'b0);
    push(8'h00, 1'b1);
    do_start();
    wait_done(400);
    for (int l = 0; l < N; l++) chk($sformatf("t3_rd_cnt_l%0d", l), 32'(rd_cnt[l]), 0);

    // All lanes two bytes under random back-pressure, plus an ignored start
    lane_count_in = {N{16'd2}};
    clear_lane_stats();
    push_all_two();
    rnd_ready = 1'b1;
    do_start();
    repeat (3) @(posedge clk);
    #1 start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    wait_done(1000);
    rnd_ready = 1'b0;
    for (int l = 0; l < N; l++) chk($sformatf("t4_rd_cnt_l%0d", l), 32'(rd_cnt[l]), 2);

    // Overflowing total 0x1_0004, then reset in the middle of the data phase
    lane_count_in = '0;
    lane_count_in[15:0]  = 16'hFFFF;
    lane_count_in[31:16] = 16'h0005;
    clear_lane_stats();
    strict = 1'b0;
    push(8'h00, 1'b0);
    push(8'h04, 1'b0);
    push(8'h00, 1'b0);
    push(8'h10, 1'b0);
    push(8'h01, 1'b0);
    push(8'h11, 1'b0);
    do_start();
    for (int k = 0; k < 400 && q.size() > 0; k++) @(negedge clk);
    chk("t5_queue_drained", 32'(q.size()), 0);
    chk("t5_overflow", 32'(overflow_out), 1);
    repeat (3) @(negedge clk);
    chk("t5_busy_mid_data", 32'(busy_out), 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_outputs_zero("mid_reset");
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset_hold");
    q.delete();
    clear_lane_stats();
    strict = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    // Stray return with no read in flight must be ignored
    @(posedge clk); #3;
    lane_valid_in[0] = 1'b1;
    lane_byte_in[7:0] = 8'hEE;
    @(negedge clk);
    chk("t5_idle_after_stray", 32'(busy_out), 0);

    // Second merge after reset must be clean
    set_sparse_counts();
    clear_lane_stats();
    push_sparse();
    do_start();
    wait_done(400);
    chk("t6_overflow", 32'(overflow_out), 0);
    for (int l = 0; l < N; l++)
      chk($sformatf("t6_rd_cnt_l%0d", l), 32'(rd_cnt[l]), (l == 0) ? 3 : (l == 2) ? 1 : 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ac_lane_merger.md
AC_LANE_MERGER -- requirements
Module: ac_lane_merger

Interface
REQ-001 SHALL have parameter NUM_LANES, default 9, number of coder output lanes merged (legal 2..16).
REQ-002 SHALL have parameter COUNT_BYTES, default 2, header byte-count field width in bytes (legal 2..4).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_in  in  1  one-cycle pulse that begins a merge.
REQ-006 SHALL have port lane_count_in  in  NUM_LANES*16  per-lane byte counts, lane L at [16L+15:16L], stable from start_in until done_out.
REQ-007 SHALL have port lane_rd_en_out  out  NUM_LANES  per-lane one-cycle read pulse.
REQ-008 SHALL have port lane_byte_in  in  NUM_LANES*8  per-lane returned byte.
REQ-009 SHALL have port lane_valid_in  in  NUM_LANES  per-lane byte-valid, exactly one cycle after the matching lane_rd_en_out.
REQ-010 SHALL have port data_out  out  8  merged output byte.
REQ-011 SHALL have port valid_out  out  1  data_out valid.
REQ-012 SHALL have port ready_in  in  1  downstream accepts data_out.
REQ-013 SHALL have port last_out  out  1  marks final byte of the merged stream.
REQ-014 SHALL have port busy_out  out  1  high from the cycle after start_in acceptance until done_out.
REQ-015 SHALL have port done_out  out  1  one-cycle pulse after last byte is accepted.
REQ-016 SHALL have port overflow_out  out  1  sticky flag: lane-count sum exceeded COUNT_BYTES*8 bits.

Function
REQ-017 SHALL implement states IDLE, SUM, PREFETCH, HEADER, DATA, DONE.
REQ-018 SHALL leave IDLE only on start_in; start_in in any other state SHALL be ignored.
REQ-019 SHALL in SUM add one lane count per cycle (lane 0 first) into a COUNT_BYTES*8-bit total, NUM_LANES cycles; carry out of the total SHALL set overflow_out and the total wraps.
REQ-020 SHALL in PREFETCH issue one lane_rd_en_out per cycle, lane 0 upward, only to lanes with nonzero count, loading each lane's remaining counter with count-1 on issue; lanes with zero count are skipped without a cycle.
REQ-021 SHALL hold one buffered byte per lane, filled on lane_valid_in; lane_valid_in for a lane with no outstanding read SHALL be ignored.
REQ-022 SHALL in HEADER emit the total as COUNT_BYTES bytes, most significant first.
REQ-023 SHALL in DATA emit bytes round-robin: from the current pointer, the next lane (wrapping NUM_LANES-1 to 0) whose buffer is full or read outstanding; lanes with empty buffer and zero remaining SHALL be skipped permanently.
REQ-024 SHALL on each data-byte acceptance from lane L pulse lane_rd_en_out[L] in the same cycle if remaining[L]>0 and decrement remaining[L].
REQ-025 SHALL deassert valid_out (bubble) while the selected lane's read is outstanding, never skipping it.
REQ-026 SHALL follow valid/ready: transfer when valid_out && ready_in; data_out and last_out SHALL stay stable while valid_out && !ready_in.
REQ-027 SHALL assert last_out with the final data byte, or with the final header byte if the total is zero.
REQ-028 SHALL in DONE pulse done_out one cycle, then return to IDLE; overflow_out clears only on reset or next start_in.
REQ-029 SHALL have latency start_in to first valid_out of 1+NUM_LANES+(nonzero lanes)+1 cycles.

Reset
REQ-030 SHALL on rst_n low, at any time including mid-merge, enter IDLE and drive data_out=0, valid_out=0, last_out=0, busy_out=0, done_out=0, overflow_out=0, lane_rd_en_out=0, clearing buffers, counters and pointer.
REQ-031 SHALL ignore lane_valid_in returns after reset release for reads issued before reset.

Structure
REQ-032 SHALL place the state enum, default NUM_LANES/COUNT_BYTES constants and byte width in shared package ac_pkg.
REQ-033 SHALL isolate next-lane selection in sub-module ac_rr_select (pointer and eligibility mask in, next lane index and found flag out, combinational).

Verification
REQ-034 SHALL cover: NUM_LANES=9, counts all 2, ready_in=1 -> header 0x00,0x12, then 18 bytes lanes 0..8,0..8, last_out on 18th, done_out one cycle later.
REQ-035 SHALL cover: counts {3,0,1,0,...0} -> header 0x00,0x04, order L0,L2,L0,L0, bubble before each L0 repeat, 2 refill pulses to lane 0 only.
REQ-036 SHALL cover: all counts 0 -> header 0x00,0x00 with last_out on second byte, no lane_rd_en_out pulses.
REQ-037 SHALL cover: ready_in toggled randomly -> data_out/last_out held while stalled, byte sequence identical to ready_in=1 run.
REQ-038 SHALL cover: COUNT_BYTES=2, counts summing to 0x1_0004 -> overflow_out=1, header 0x00,0x04.
REQ-039 SHALL cover: rst_n low mid-DATA, then new start_in -> all outputs 0 during reset, second merge output correct.
